run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side run controller that drives the processor core's `req`/`done` start–completion handshake. It launches a fixed series of programs back to back and measures each program's cycle count with a timeout guard. It reports one result record per program and flags completion of the whole series. It sits beside the core in the test harness: its `core_req` drives the core's `req` input, and its `core_done` is driven from the core's `done` output.

## Interface
- `NPROG`, default 3: programs per series; `prog_idx` counts 0..NPROG-1.
- `CW`, default 16: width of the cycle counter and `res_cycles`.
- `TMO`, default 4096: RUN cycles allowed before a timeout is declared; must satisfy 1 ≤ TMO ≤ 2^CW-1.
- `REQ_CYC`, default 2: number of cycles `core_req` is held high per launch; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `start`  in  1  request to begin a series; honoured only in IDLE and FINISH.
- `core_done`  in  1  the core's `done` output.
- `core_req`  out  1  drives the core's `req` input.
- `prog_idx`  out  $clog2(NPROG)  index of the program being launched or run.
- `busy`  out  1  high in REQ, RUN and LOG.
- `res_valid`  out  1  one-cycle strobe; the result record is valid.
- `res_idx`  out  $clog2(NPROG)  program index of the record.
- `res_cycles`  out  CW  measured RUN cycles, or TMO on timeout.
- `res_timeout`  out  1  record ended by timeout, not by `done`.
- `all_done`  out  1  the series is complete; held high in FINISH.

## Operation
- States: IDLE, REQ, RUN, LOG, FINISH. All outputs are registered.
- Reset (`reset`=0) produces state IDLE, and sets `prog_idx`, `core_req`, `busy`, `res_valid`, `res_idx`, `res_cycles`, `res_timeout`, `all_done`, the cycle counter and the `done_q` register all to 0.
- **IDLE:** `start`=1 moves to REQ with `prog_idx`=0.
- **REQ:** `core_req`=1 for exactly REQ_CYC cycles, then the state moves to RUN. The cycle counter is cleared on entry to RUN.
- **RUN:** `core_req`=0 and the counter increments every cycle.
  - `rise` = `core_done` & ~`done_q`, where `done_q` registers `core_done` every cycle in every state.
  - A high level of `core_done` carried over from a previous program is not a rise and does not end RUN.
  - If `rise` occurs, the state moves to LOG with `res_cycles` = the number of RUN cycles including the rise cycle (a rise on the first RUN cycle gives 1) and `res_timeout`=0.
  - Otherwise, when the counter reaches TMO, the state moves to LOG with `res_cycles`=TMO and `res_timeout`=1.
  - If both happen in the same cycle, the rise wins: `res_timeout`=0 and `res_cycles`=TMO.
- **LOG:** lasts one cycle, with `res_valid`=1 and `res_idx`=`prog_idx`.
  - If `prog_idx`=NPROG-1, the next state is FINISH.
  - Otherwise `prog_idx` increments and the next state is REQ.
- **FINISH:** `all_done`=1 and `busy`=0.
  - `start`=1 clears `all_done`, sets `prog_idx` to 0 and moves to REQ.
  - `res_*` outputs keep the last record, but `res_valid`=0.
- `start` is ignored in REQ, RUN and LOG.
- `core_done` is ignored for state transitions in IDLE, REQ, LOG and FINISH. It is still sampled into `done_q` in those states.
- Asserting reset mid-series aborts it immediately: the block enters IDLE and no LOG record is emitted.

## Timing
- Launch latency: with `start` sampled at edge k, `core_req` is high from cycle k+1 through k+REQ_CYC. RUN begins at k+REQ_CYC+1.
- Completion latency: a `rise` sampled at edge m gives `res_valid` in cycle m+1. The next `core_req` starts in cycle m+2.
- Timeout: the LOG cycle follows the TMO-th RUN cycle.
- Per-program overhead, excluding RUN: REQ_CYC + 1 cycles.
- `all_done` rises in the cycle after the final LOG cycle.
- Counter arithmetic: unsigned CW-bit. The counter never exceeds TMO, so it never wraps.

## Test plan
- **Basic series:** NPROG=3, REQ_CYC=2. Pulse `start`; the model raises `core_done` on the 10th, 20th and 5th RUN cycle of the three programs. Required: three `res_valid` strobes with (idx, cycles, timeout) = (0,10,0), (1,20,0), (2,5,0), then `all_done`=1 and `busy`=0.
- **Stale done:** `core_done` held at 1 from the end of program 0 through REQ, falls on the 3rd RUN cycle and rises on the 8th. Required: `res_cycles`=8 for program 1, with no early record.
- **Timeout:** TMO=16 and `core_done` stays at 0. Required: `res_cycles`=16 and `res_timeout`=1, and the series continues to the next program.
- **Tie:** the rise occurs on RUN cycle 16 with TMO=16. Required: `res_timeout`=0 and `res_cycles`=16.
- **Start while busy:** `start` pulsed during RUN of program 1 is ignored, with no reset of `prog_idx`. A later `start` in FINISH restarts the series with `prog_idx`=0 and clears `all_done`.
- **Reset mid-RUN:** `reset`=0 asserted between clock edges. Required: all outputs read 0 immediately, `core_req`=0, no `res_valid`, and the block stays in IDLE until `start`.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: launches NPROG core programs back to back over the req/done handshake and times each one.
// Latency: core_req rises the cycle after start is sampled; a result record strobes the cycle after done rises or the timeout hits.
// Backpressure: none; start is ignored while busy and each result is a one-cycle strobe with no stall.
module run_sequencer #(
   parameter int NPROG   = 3,
   parameter int CW      = 16,
   parameter int TMO     = 4096,
   parameter int REQ_CYC = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     core_done,
   output logic                     core_req,
   output logic [$clog2(NPROG)-1:0] prog_idx,
   output logic                     busy,
   output logic                     res_valid,
   output logic [$clog2(NPROG)-1:0] res_idx,
   output logic [CW-1:0]            res_cycles,
   output logic                     res_timeout,
   output logic                     all_done
);

   localparam int IW = $clog2(NPROG);
   localparam int RW = (REQ_CYC > 1) ? $clog2(REQ_CYC) : 1;

   localparam logic [CW-1:0] TMO_C    = CW'(TMO);
   localparam logic [RW-1:0] REQ_LAST = RW'(REQ_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NPROG - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RUN,
      S_LOG,
      S_FINISH
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [RW-1:0]   req_cnt;
   logic            done_q;
   logic            rise;

   // cnt_nxt is the 1-based index of the RUN cycle currently in progress
   assign cnt_nxt = cnt + CW'(1);
   // only a fresh 0->1 edge of done ends a run; a level left over from the last program does not
   assign rise    = core_done & ~done_q;

   // done history, sampled every cycle regardless of state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= core_done;
      end
   end

   // series controller: launch, time, log each program, then park in FINISH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         req_cnt     <= '0;
         prog_idx    <= '0;
         core_req    <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_idx     <= '0;
         res_cycles  <= '0;
         res_timeout <= 1'b0;
         all_done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FINISH: begin
               if (start) begin
                  state    <= S_REQ;
                  prog_idx <= '0;
                  req_cnt  <= '0;
                  core_req <= 1'b1;
                  busy     <= 1'b1;
                  all_done <= 1'b0;
               end
            end
            S_REQ: begin
               if (req_cnt == REQ_LAST) begin
                  state    <= S_RUN;
                  core_req <= 1'b0;
                  cnt      <= '0;
               end else begin
                  req_cnt <= req_cnt + RW'(1);
               end
            end
            S_RUN: begin
               // rise is tested first so a done arriving on the TMO-th cycle is not a timeout
               if (rise) begin
                  state       <= S_LOG;
                  res_valid   <= 1'b1;
                  res_idx     <= prog_idx;
                  res_cycles  <= cnt_nxt;
                  res_timeout <= 1'b0;
               end else if (cnt_nxt == TMO_C) begin
                  state       <= S_LOG;
                  res_valid   <= 1'b1;
                  res_idx     <= prog_idx;
                  res_cycles  <= TMO_C;
                  res_timeout <= 1'b1;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            S_LOG: begin
               res_valid <= 1'b0;
               if (prog_idx == IDX_LAST) begin
                  state    <= S_FINISH;
                  busy     <= 1'b0;
                  all_done <= 1'b1;
               end else begin
                  state    <= S_REQ;
                  prog_idx <= prog_idx + IW'(1);
                  req_cnt  <= '0;
                  core_req <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: two instances (long and short timeout) checked every cycle against a timestamp model.
// Latency: stimulus changes 1-2 time units after a rising edge; outputs are compared on the falling edge.
// Backpressure: none; every wait on the design is bounded and an expired bound counts as a failure.
module tb_run_sequencer;

   localparam int NPROG   = 3;
   localparam int CW      = 16;
   localparam int REQ_CYC = 2;
   localparam int TMO_A   = 4096;
   localparam int TMO_B   = 16;

   typedef struct {
      int d;
      int idx;
      int cyc;
      int to;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n0, rst_n1;
   logic          start_s [2];
   logic          done_s  [2];
   logic          cr [2], bz [2], rv [2], rt [2], ad [2];
   logic [1:0]    pi [2], ri [2];
   logic [CW-1:0] rc [2];

   run_sequencer #(.NPROG(NPROG), .CW(CW), .TMO(TMO_A), .REQ_CYC(REQ_CYC)) dut_a (
      .clk(clk), .reset(rst_n0), .start(start_s[0]), .core_done(done_s[0]),
      .core_req(cr[0]), .prog_idx(pi[0]), .busy(bz[0]), .res_valid(rv[0]),
      .res_idx(ri[0]), .res_cycles(rc[0]), .res_timeout(rt[0]), .all_done(ad[0]));

   run_sequencer #(.NPROG(NPROG), .CW(CW), .TMO(TMO_B), .REQ_CYC(REQ_CYC)) dut_b (
      .clk(clk), .reset(rst_n1), .start(start_s[1]), .core_done(done_s[1]),
      .core_req(cr[1]), .prog_idx(pi[1]), .busy(bz[1]), .res_valid(rv[1]),
      .res_idx(ri[1]), .res_cycles(rc[1]), .res_timeout(rt[1]), .all_done(ad[1]));

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Model: a series is "active" from its start edge; each program occupies REQ_CYC
   // request cycles beginning at m_treq, then RUN cycles until a LOG cycle at m_tlog.
   bit m_act [2], m_fin [2], m_dq [2], m_rto [2];
   int m_treq [2], m_tlog [2], m_pidx [2], m_ridx [2], m_rcyc [2];
   int plan [2][3];   // per program: RUN cycle of the done rise, 0 = never, -1 = stale-done pattern
   rec_t recs [$];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mreset(input int d);
      m_act[d] = 0; m_fin[d] = 0; m_dq[d] = 0; m_rto[d] = 0;
      m_treq[d] = 0; m_tlog[d] = -1; m_pidx[d] = 0; m_ridx[d] = 0; m_rcyc[d] = 0;
   endtask

   // advance model d across the edge that ends cycle e
   task automatic mstep(input int d, input bit st, input bit dn, input int e);
      int rs, k, tmo;
      tmo = (d == 0) ? TMO_A : TMO_B;
      rs  = m_treq[d] + REQ_CYC;
      if (!m_act[d]) begin
         if (st) begin
            m_act[d] = 1; m_fin[d] = 0; m_pidx[d] = 0; m_treq[d] = e + 1; m_tlog[d] = -1;
         end
      end else if (m_tlog[d] == e) begin
         if (m_pidx[d] == NPROG - 1) begin
            m_act[d] = 0; m_fin[d] = 1;
         end else begin
            m_pidx[d] = m_pidx[d] + 1; m_treq[d] = e + 1; m_tlog[d] = -1;
         end
      end else if (m_tlog[d] < 0 && e >= rs) begin
         k = e - rs + 1;
         if (dn && !m_dq[d]) begin
            m_tlog[d] = e + 1; m_ridx[d] = m_pidx[d]; m_rcyc[d] = k; m_rto[d] = 0;
         end else if (k == tmo) begin
            m_tlog[d] = e + 1; m_ridx[d] = m_pidx[d]; m_rcyc[d] = tmo; m_rto[d] = 1;
         end
      end
      m_dq[d] = dn;
   endtask

   task automatic model_edge();
      if (!rst_n0) mreset(0); else mstep(0, start_s[0], done_s[0], cyc);
      if (!rst_n1) mreset(1); else mstep(1, start_s[1], done_s[1], cyc);
      cyc++;
   endtask

   always @(posedge clk) model_edge();
   always @(negedge rst_n0) mreset(0);
   always @(negedge rst_n1) mreset(1);

   // emulated core: done level derived from the plan of the program in flight
   function automatic bit core_level(input int d);
      int rs, k, p;
      if (!m_act[d]) return 1'($urandom_range(0, 3) == 0);
      rs = m_treq[d] + REQ_CYC;
      if (m_tlog[d] == cyc) begin
         if (m_pidx[d] < NPROG - 1 && plan[d][m_pidx[d] + 1] == -1) return 1'b1;
         return 1'($urandom_range(0, 1));
      end
      p = plan[d][m_pidx[d]];
      if (cyc < rs) return (p == -1);
      k = cyc - rs + 1;
      if (p == -1) return (k < 3) || (k >= 8);
      return (p > 0) && (k >= p);
   endfunction

   task automatic drive_done();
      done_s[0] = core_level(0);
      done_s[1] = core_level(1);
   endtask

   always @(posedge clk) begin
      #2;
      drive_done();
   end

   // per-cycle comparison of both instances against the model
   task automatic compare_all();
      string t;
      for (int d = 0; d < 2; d++) begin
         t = (d == 0) ? "A" : "B";
         chk({t, ".core_req"}, int'(cr[d]),
             int'(m_act[d] && cyc >= m_treq[d] && cyc < m_treq[d] + REQ_CYC));
         chk({t, ".busy"}, int'(bz[d]), int'(m_act[d]));
         chk({t, ".res_valid"}, int'(rv[d]), int'(m_act[d] && m_tlog[d] == cyc));
         chk({t, ".all_done"}, int'(ad[d]), int'(m_fin[d]));
         chk({t, ".prog_idx"}, int'(pi[d]), m_pidx[d]);
         chk({t, ".res_idx"}, int'(ri[d]), m_ridx[d]);
         chk({t, ".res_cycles"}, int'(rc[d]), m_rcyc[d]);
         chk({t, ".res_timeout"}, int'(rt[d]), int'(m_rto[d]));
         if (rv[d]) recs.push_back('{d, int'(ri[d]), int'(rc[d]), int'(rt[d])});
      end
   endtask

   always @(negedge clk) compare_all();

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int d);
      @(posedge clk); #1; start_s[d] = 1'b1;
      @(posedge clk); #1; start_s[d] = 1'b0;
   endtask

   task automatic wait_fin(input int d, input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (ad[d]) return;
      end
      n_chk++; n_fail++;
      $display("FAIL %s: all_done not seen within %0d cycles", nm, budget);
   endtask

   task automatic wait_run_p1(input int d, input string nm);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (pi[d] == 2'd1 && bz[d] && !cr[d] && !rv[d]) return;
      end
      n_chk++; n_fail++;
      $display("FAIL %s: RUN of program 1 not reached", nm);
   endtask

   function automatic int count_recs(input int d);
      int n = 0;
      foreach (recs[i]) if (recs[i].d == d) n++;
      return n;
   endfunction

   task automatic chk_rec(input int d, input int idx, input int cy, input int to, input string nm);
      int pos = -1;
      rec_t r;
      foreach (recs[i]) if (pos < 0 && recs[i].d == d) pos = i;
      if (pos < 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s: record missing, expected idx %0d cycles %0d timeout %0d", nm, idx, cy, to);
         return;
      end
      r = recs[pos];
      recs.delete(pos);
      chk({nm, ".idx"}, r.idx, idx);
      chk({nm, ".cycles"}, r.cyc, cy);
      chk({nm, ".timeout"}, r.to, to);
   endtask

   task automatic scen_a();
      plan[0] = '{10, 20, 5};
      pulse_start(0);
      wait_fin(0, 300, "A.basic");
      chk_rec(0, 0, 10, 0, "A.basic.r0");
      chk_rec(0, 1, 20, 0, "A.basic.r1");
      chk_rec(0, 2, 5, 0, "A.basic.r2");
      chk("A.basic.all_done", int'(ad[0]), 1);
      chk("A.basic.busy", int'(bz[0]), 0);
      for (int s = 0; s < 4; s++) begin
         for (int p = 0; p < NPROG; p++) plan[0][p] = $urandom_range(1, 40);
         cyc_wait($urandom_range(0, 5));
         pulse_start(0);
         wait_fin(0, 400, "A.rand");
         for (int p = 0; p < NPROG; p++) chk_rec(0, p, plan[0][p], 0, "A.rand");
      end
   endtask

   task automatic scen_b();
      int p;
      // stale done on program 1, plain timeout on program 2
      plan[1] = '{4, -1, 0};
      pulse_start(1);
      wait_fin(1, 300, "B.stale");
      chk_rec(1, 0, 4, 0, "B.s1.r0");
      chk_rec(1, 1, 8, 0, "B.stale.r1");
      chk_rec(1, 2, 16, 1, "B.timeout.r2");

      // tie on program 0, start pulse ignored during RUN of program 1
      plan[1] = '{16, 0, 3};
      pulse_start(1);
      wait_run_p1(1, "B.busy_start");
      cyc_wait(3);
      start_s[1] = 1'b1;
      cyc_wait(1);
      start_s[1] = 1'b0;
      chk("B.busy_start.prog_idx", int'(pi[1]), 1);
      chk("B.busy_start.busy", int'(bz[1]), 1);
      wait_fin(1, 300, "B.tie");
      chk_rec(1, 0, 16, 0, "B.tie.r0");
      chk_rec(1, 1, 16, 1, "B.s2.r1");
      chk_rec(1, 2, 3, 0, "B.s2.r2");

      // restart from FINISH, then abort with reset in the middle of program 1
      plan[1] = '{6, 12, 9};
      @(posedge clk); #1; start_s[1] = 1'b1;
      @(posedge clk); #1; start_s[1] = 1'b0;
      chk("B.restart.all_done", int'(ad[1]), 0);
      chk("B.restart.prog_idx", int'(pi[1]), 0);
      chk("B.restart.core_req", int'(cr[1]), 1);
      wait_run_p1(1, "B.reset_run");
      cyc_wait(2);
      #2 rst_n1 = 1'b0;
      #1;
      chk("B.rst.core_req", int'(cr[1]), 0);
      chk("B.rst.busy", int'(bz[1]), 0);
      chk("B.rst.res_valid", int'(rv[1]), 0);
      chk("B.rst.all_done", int'(ad[1]), 0);
      chk("B.rst.prog_idx", int'(pi[1]), 0);
      chk("B.rst.res_idx", int'(ri[1]), 0);
      chk("B.rst.res_cycles", int'(rc[1]), 0);
      chk("B.rst.res_timeout", int'(rt[1]), 0);
      @(posedge clk); @(posedge clk);
      #3 rst_n1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc_wait(1);
         chk("B.idle_after_rst.busy", int'(bz[1]), 0);
         chk("B.idle_after_rst.core_req", int'(cr[1]), 0);
      end
      chk_rec(1, 0, 6, 0, "B.s3.r0");
      chk("B.no_abort_record", count_recs(1), 0);

      // random series; timeouts whenever the rise is missing or lands after cycle 16
      for (int s = 0; s < 4; s++) begin
         for (int q = 0; q < NPROG; q++) plan[1][q] = $urandom_range(0, 20);
         cyc_wait($urandom_range(0, 5));
         pulse_start(1);
         wait_fin(1, 300, "B.rand");
         for (int q = 0; q < NPROG; q++) begin
            p = plan[1][q];
            if (p == 0 || p > TMO_B) chk_rec(1, q, TMO_B, 1, "B.rand");
            else chk_rec(1, q, p, 0, "B.rand");
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mreset(0);
      mreset(1);
      plan[0] = '{0, 0, 0};
      plan[1] = '{0, 0, 0};
      start_s[0] = 1'b0; start_s[1] = 1'b0;
      done_s[0] = 1'b0;  done_s[1] = 1'b0;
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      #1 rst_n0 = 1'b0; rst_n1 = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset.core_req", int'(cr[d]), 0);
         chk("reset.busy", int'(bz[d]), 0);
         chk("reset.all_done", int'(ad[d]), 0);
         chk("reset.prog_idx", int'(pi[d]), 0);
      end
      #20 rst_n0 = 1'b1; rst_n1 = 1'b1;
      fork
         scen_a();
         scen_b();
      join
      cyc_wait(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
